// File: rtl/hilo_pkg.sv
// hilo_pkg -- shared definitions for the HI/LO register unit.
//   div_state_t : iterative divider FSM states (IDLE, RUN, DONE)
//   DIV_ITERS   : restoring-division iterations, one quotient bit each
//   DIV_ZERO_LO : LO value written on divide-by-zero
//   mag32       : two's-complement magnitude helper for signed operands
package hilo_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int unsigned DIV_ITERS   = 32;
  localparam logic [31:0] DIV_ZERO_LO = 32'hFFFF_FFFF;

  // Magnitude of v when take_abs is set and v is negative; otherwise v.
  // 0x80000000 maps to itself, which is the correct unsigned magnitude.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic take_abs);
    return (take_abs && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div32_seq.sv
// div32_seq -- sequential 32-bit restoring divider (DIV / DIVU).
//   clk, rst      : clock, asynchronous active-high reset
//   start         : launch; sampled only in IDLE together with signed_op, a, b
//   signed_op     : 1 = signed divide, 0 = unsigned divide
//   a, b          : dividend, divisor
//   busy          : registered, high whenever the FSM is not in IDLE
//   done          : high during DONE; quotient/remainder valid for writeback
//   quotient      : signed-corrected quotient (modulo 2^32)
//   remainder     : signed-corrected remainder (sign of dividend)
// Divide-by-zero bypasses RUN: quotient = all ones, remainder = dividend.
module div32_seq
  import hilo_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  div_state_t  state, state_next;
  logic [4:0]  count;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] dvsr;
  logic        neg_q;
  logic        neg_r;
  logic        last_iter;
  logic [32:0] rem_shift;
  logic [32:0] rem_diff;

  assign last_iter = (count == 5'(DIV_ITERS - 1));

  // Partial remainder always stays below the divisor, so rem_shift < 2*dvsr:
  // bit 32 of the difference is a clean borrow flag (set means "restore").
  always_comb begin
    rem_shift = {rem, quo[31]};
    rem_diff  = rem_shift - {1'b0, dvsr};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (b == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (last_iter) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
    end else begin
      busy <= (state_next != IDLE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      quo   <= '0;
      rem   <= '0;
      dvsr  <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            count <= '0;
            if (b == '0) begin
              // Raw pass-through with sign fix-up disabled.
              quo   <= DIV_ZERO_LO;
              rem   <= a;
              dvsr  <= b;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
            end else begin
              quo   <= mag32(a, signed_op);
              rem   <= '0;
              dvsr  <= mag32(b, signed_op);
              neg_q <= signed_op & (a[31] ^ b[31]);
              neg_r <= signed_op & a[31];
            end
          end
        end
        RUN: begin
          if (!rem_diff[32]) begin
            rem <= rem_diff[31:0];
            quo <= {quo[30:0], 1'b1};
          end else begin
            rem <= rem_shift[31:0];
            quo <= {quo[30:0], 1'b0};
          end
          count <= count + 5'd1;
        end
        default: begin
        end
      endcase
    end
  end

  assign done      = (state == DONE);
  assign quotient  = neg_q ? (~quo + 32'd1) : quo;
  assign remainder = neg_r ? (~rem + 32'd1) : rem;

endmodule

// File: rtl/hi_lo_unit.sv
// hi_lo_unit -- MIPS-style HI/LO register pair with optional iterative divider.
//   Clk, Rst   : clock, asynchronous active-high reset
//   HiLoEn     : multiply-family write, HI/LO <= HiLoWrite[63:32]/[31:0]
//   MthiEn     : HI <= MoveData
//   MtloEn     : LO <= MoveData
//   DivStart   : one-cycle DIV/DIVU launch with DivSigned, DivA, DivB
//   HiLoRead   : {HI, LO} straight from the registers
//   Busy       : divider active; all writes and launches are dropped meanwhile
// Build option: define HILO_DIV_EN to include the divider. Without it the
// divide inputs are ignored and Busy is constantly 0.
module hi_lo_unit
  import hilo_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst,
  input  logic        HiLoEn,
  input  logic [63:0] HiLoWrite,
  input  logic        MthiEn,
  input  logic        MtloEn,
  input  logic [31:0] MoveData,
  input  logic        DivStart,
  input  logic        DivSigned,
  input  logic [31:0] DivA,
  input  logic [31:0] DivB,
  output logic [63:0] HiLoRead,
  output logic        Busy
);

  logic [31:0] hi, hi_next;
  logic [31:0] lo, lo_next;
  logic        div_busy;
  logic        div_done;
  logic [31:0] div_q;
  logic [31:0] div_r;

`ifdef HILO_DIV_EN
  div32_seq u_div (
    .clk       (Clk),
    .rst       (Rst),
    .start     (DivStart & ~div_busy),
    .signed_op (DivSigned),
    .a         (DivA),
    .b         (DivB),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );
`else
  logic unused_div_inputs;

  assign unused_div_inputs = ^{DivStart, DivSigned, DivA, DivB};
  assign div_busy          = 1'b0;
  assign div_done          = 1'b0;
  assign div_q             = '0;
  assign div_r             = '0;
`endif

  // Divider writeback wins outright; it only occurs while Busy is high, when
  // every other strobe is dropped anyway.
  always_comb begin
    hi_next = hi;
    lo_next = lo;
    if (div_done) begin
      hi_next = div_r;
      lo_next = div_q;
    end else if (!div_busy) begin
      if (HiLoEn) begin
        hi_next = HiLoWrite[63:32];
        lo_next = HiLoWrite[31:0];
      end else begin
        if (MthiEn) hi_next = MoveData;
        if (MtloEn) lo_next = MoveData;
      end
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      hi <= '0;
      lo <= '0;
    end else begin
      hi <= hi_next;
      lo <= lo_next;
    end
  end

  assign HiLoRead = {hi, lo};
  assign Busy     = div_busy;

endmodule

// File: tb/tb_hi_lo_unit.sv
module tb_hi_lo_unit;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        HiLoEn;
  logic [63:0] HiLoWrite;
  logic        MthiEn;
  logic        MtloEn;
  logic [31:0] MoveData;
  logic        DivStart;
  logic        DivSigned;
  logic [31:0] DivA;
  logic [31:0] DivB;
  logic [63:0] HiLoRead;
  logic        Busy;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  // Reference architectural state.
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  always #5 Clk = ~Clk;

  hi_lo_unit dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .HiLoEn    (HiLoEn),
    .HiLoWrite (HiLoWrite),
    .MthiEn    (MthiEn),
    .MtloEn    (MtloEn),
    .MoveData  (MoveData),
    .DivStart  (DivStart),
    .DivSigned (DivSigned),
    .DivA      (DivA),
    .DivB      (DivB),
    .HiLoRead  (HiLoRead),
    .Busy      (Busy)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_inputs;
    HiLoEn    = 1'b0;
    HiLoWrite = '0;
    MthiEn    = 1'b0;
    MtloEn    = 1'b0;
    MoveData  = '0;
    DivStart  = 1'b0;
    DivSigned = 1'b0;
    DivA      = '0;
    DivB      = '0;
  endtask

  task automatic test_reset;
    Rst = 1'b1;
    clear_inputs();
    HiLoEn    = 1'b1;
    HiLoWrite = {$urandom, $urandom};
    repeat (2) tick();
    vectors++;
    if (HiLoRead !== 64'd0) begin
      miscompares++;
      $display("FAIL reset_hilo: got %h expected %h", HiLoRead, 64'd0);
    end
    vectors++;
    if (Busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_busy: got %b expected 0", Busy);
    end
    HiLoEn = 1'b0;
    #2 Rst = 1'b0;
    m_hi = '0;
    m_lo = '0;
    tick();
    vectors++;
    if (HiLoRead !== 64'd0) begin
      miscompares++;
      $display("FAIL reset_release: got %h expected %h", HiLoRead, 64'd0);
    end
  endtask

  task automatic test_hilo_write;
    logic [63:0] w;
    for (int i = 0; i < 12; i++) begin
      w = (i == 0) ? 64'h0000_0001_0000_0002 : {$urandom, $urandom};
      HiLoEn    = 1'b1;
      HiLoWrite = w;
      #1;
      vectors++;
      if (HiLoRead !== {m_hi, m_lo}) begin
        miscompares++;
        $display("FAIL hilo_no_bypass: got %h expected %h", HiLoRead, {m_hi, m_lo});
      end
      tick();
      m_hi = w[63:32];
      m_lo = w[31:0];
      HiLoEn = 1'b0;
      vectors++;
      if (HiLoRead !== w) begin
        miscompares++;
        $display("FAIL hilo_write: got %h expected %h", HiLoRead, w);
      end
      tick();
    end
  endtask

  task automatic test_moves;
    logic [63:0] w;
    logic [31:0] d;
    for (int i = 0; i < 4; i++) begin
      w = {$urandom, $urandom};
      d = $urandom;
      MoveData  = d;
      HiLoWrite = w;
      HiLoEn    = (i == 3);
      MthiEn    = (i == 0) || (i == 2) || (i == 3);
      MtloEn    = (i == 1) || (i == 2);
      tick();
      if (i == 3) begin
        m_hi = w[63:32];
        m_lo = w[31:0];
      end else begin
        if (i != 1) m_hi = d;
        if (i != 0) m_lo = d;
      end
      clear_inputs();
      vectors++;
      if (HiLoRead !== {m_hi, m_lo}) begin
        miscompares++;
        $display("FAIL move_%0d: got %h expected %h", i, HiLoRead, {m_hi, m_lo});
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] w;
    logic [31:0] d;
    logic        en, th, tl;
    for (int i = 0; i < 30; i++) begin
      w  = {$urandom, $urandom};
      d  = $urandom;
      en = 1'($urandom);
      th = 1'($urandom);
      tl = 1'($urandom);
      HiLoEn = en; HiLoWrite = w; MthiEn = th; MtloEn = tl; MoveData = d;
      tick();
      if (en) begin
        m_hi = w[63:32];
        m_lo = w[31:0];
      end else begin
        if (th) m_hi = d;
        if (tl) m_lo = d;
      end
      vectors++;
      if (HiLoRead !== {m_hi, m_lo}) begin
        miscompares++;
        $display("FAIL back_to_back_%0d: got %h expected %h", i, HiLoRead, {m_hi, m_lo});
      end
    end
    clear_inputs();
  endtask

`ifdef HILO_DIV_EN
  function automatic void div_ref(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
    longint sa, sb, ma, mb, mq, mr;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
      return;
    end
    sa = sgn ? {{32{a[31]}}, a} : {32'd0, a};
    sb = sgn ? {{32{b[31]}}, b} : {32'd0, b};
    ma = (sa < 0) ? -sa : sa;
    mb = (sb < 0) ? -sb : sb;
    mq = ma / mb;
    mr = ma % mb;
    if ((sa < 0) != (sb < 0)) mq = -mq;
    if (sa < 0) mr = -mr;
    q = mq[31:0];
    r = mr[31:0];
  endfunction

  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic with_write);
    logic [31:0] eq, er;
    logic [63:0] w;
    int          n;
    int          exp_n;
    div_ref(sgn, a, b, eq, er);
    exp_n = (b == 32'd0) ? 1 : 33;
    DivStart = 1'b1; DivSigned = sgn; DivA = a; DivB = b;
    if (with_write) begin
      w = {$urandom, $urandom};
      HiLoEn = 1'b1;
      HiLoWrite = w;
      m_hi = w[63:32];
      m_lo = w[31:0];
    end
    tick();
    DivStart = 1'b0; HiLoEn = 1'b0;
    DivA = $urandom; DivB = $urandom; DivSigned = 1'($urandom);
    vectors++;
    if (Busy !== 1'b1) begin
      miscompares++;
      $display("FAIL div_busy_start: got %b expected 1", Busy);
    end
    vectors++;
    if (HiLoRead !== {m_hi, m_lo}) begin
      miscompares++;
      $display("FAIL div_launch_write: got %h expected %h", HiLoRead, {m_hi, m_lo});
    end
    n = 0;
    while (Busy === 1'b1 && n < 100) begin
      HiLoEn    = 1'($urandom);
      HiLoWrite = {$urandom, $urandom};
      MthiEn    = (n == 0) ? 1'b1 : 1'($urandom);
      MtloEn    = 1'($urandom);
      MoveData  = (n == 0) ? 32'h0000_ABCD : $urandom;
      DivStart  = 1'($urandom);
      tick();
      n++;
      if (Busy === 1'b1) begin
        vectors++;
        if (HiLoRead !== {m_hi, m_lo}) begin
          miscompares++;
          $display("FAIL div_stall_hold: got %h expected %h", HiLoRead, {m_hi, m_lo});
        end
      end
    end
    clear_inputs();
    vectors++;
    if (n != exp_n) begin
      miscompares++;
      $display("FAIL div_busy_cycles: got %0d expected %0d", n, exp_n);
    end
    m_hi = er;
    m_lo = eq;
    vectors++;
    if (HiLoRead !== {m_hi, m_lo}) begin
      miscompares++;
      $display("FAIL div_result %h/%h s=%b: got %h expected %h", a, b, sgn, HiLoRead, {m_hi, m_lo});
    end
    tick();
  endtask

  task automatic test_divide;
    logic [31:0] a, b;
    run_div(1'b0, 32'd100, 32'd7, 1'b0);
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_div(1'b0, 32'd5, 32'd0, 1'b0);
    run_div(1'b1, 32'd5, 32'd0, 1'b0);
    run_div(1'b0, $urandom, 32'd3, 1'b1);
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = $urandom_range(1, 20);
        1:       b = (i == 1) ? 32'd0 : ~32'($urandom_range(0, 5));
        default: b = $urandom;
      endcase
      run_div(1'($urandom), a, b, 1'($urandom));
    end
  endtask
`else
  task automatic test_no_divider;
    logic [63:0] w;
    for (int i = 0; i < 40; i++) begin
      w = {$urandom, $urandom};
      DivStart  = 1'($urandom);
      DivSigned = 1'($urandom);
      DivA      = $urandom;
      DivB      = (i % 3 == 0) ? 32'd0 : $urandom;
      HiLoEn    = (i % 2 == 0);
      HiLoWrite = w;
      tick();
      if (i % 2 == 0) begin
        m_hi = w[63:32];
        m_lo = w[31:0];
      end
      vectors++;
      if (Busy !== 1'b0 || HiLoRead !== {m_hi, m_lo}) begin
        miscompares++;
        $display("FAIL nodiv_%0d: got busy=%b hilo=%h expected busy=0 hilo=%h",
                 i, Busy, HiLoRead, {m_hi, m_lo});
      end
    end
    clear_inputs();
  endtask
`endif

  task automatic test_reset_abort;
    logic [63:0] w;
    w = {$urandom | 32'h1, $urandom | 32'h1};
    HiLoEn = 1'b1;
    HiLoWrite = w;
    tick();
    HiLoEn = 1'b0;
    DivStart = 1'b1; DivSigned = 1'b0; DivA = 32'd1000; DivB = 32'd3;
    tick();
    DivStart = 1'b0;
    repeat (10) tick();
    #3 Rst = 1'b1;
    #1;
    vectors++;
    if (HiLoRead !== 64'd0 || Busy !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_async: got busy=%b hilo=%h expected busy=0 hilo=0", Busy, HiLoRead);
    end
    #2 Rst = 1'b0;
    m_hi = '0;
    m_lo = '0;
    for (int i = 0; i < 40; i++) begin
      tick();
      vectors++;
      if (HiLoRead !== 64'd0 || Busy !== 1'b0) begin
        miscompares++;
        $display("FAIL abort_after_%0d: got busy=%b hilo=%h expected busy=0 hilo=0",
                 i, Busy, HiLoRead);
      end
    end
  endtask

  initial begin
    test_reset();
    test_hilo_write();
    test_moves();
    test_back_to_back();
`ifdef HILO_DIV_EN
    test_divide();
`else
    test_no_divider();
`endif
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
